depacketizer: RTL

Width-reducing serializer, the transmit-side counterpart of the byte packetizer. Accepts one DATA_WIDTH-bit word over a valid/ready handshake and emits its bytes, most-significant byte first, over a byte valid/ready handshake. Sits between the DDR read-back FIFO and the UART transmitter. A word packed by the packetizer and sent through this block reproduces the original byte stream.

---
 rtl/uart_fifo_pkg.sv | 14 +
 rtl/depacketizer_if.sv | 26 ++
 rtl/depacketizer.sv | 77 +++++++
 3 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared UART/FIFO datapath constants and helpers, used by both the packetizer
// and the depacketizer.
package uart_fifo_pkg;

  localparam int BYTE_WIDTH = 8;

  // Width of a byte index for a word of n_bytes bytes. A one-byte word still gets a 1-bit counter.
  function automatic int byte_cnt_width(input int n_bytes);
    int w;
    w = $clog2(n_bytes);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/depacketizer_if.sv
// Word-in / byte-out handshake bundle for the depacketizer.
interface depacketizer_if
  import uart_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16
);
  // Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high. A valid source holds its payload steady until that transfer happens.
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_ready;
  logic                  o_valid;
  logic [BYTE_WIDTH-1:0] o_data;
  logic                  i_ready;
  logic                  o_busy;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_busy
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_busy
  );
endinterface

// File: rtl/depacketizer.sv
// Serializes one DATA_WIDTH-bit word into bytes, most-significant byte first.
// The next word can be accepted on the same edge that hands off the last byte.
module depacketizer
  import uart_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  depacketizer_if.slave bus
);

  localparam int BYTES_COUNT = DATA_WIDTH / BYTE_WIDTH;
  localparam int CW          = byte_cnt_width(BYTES_COUNT);
  localparam logic [CW-1:0] LAST_IDX = CW'(BYTES_COUNT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CW-1:0]         cnt_q;
  logic                  last_byte;

  assign last_byte = (state_q == SEND) && (cnt_q == LAST_IDX);

  // Only combinational path: lets a new word in on the same edge the last byte leaves.
  always_comb begin
    bus.o_ready = 1'b0;
    if (!i_rst) begin
      bus.o_ready = (state_q == IDLE) || (last_byte && bus.i_ready);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            shift_q <= bus.i_data;
            cnt_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (bus.i_ready) begin
            if (cnt_q == LAST_IDX) begin
              if (bus.i_valid) begin
                shift_q <= bus.i_data;
                cnt_q   <= '0;
              end else begin
                shift_q <= shift_q << BYTE_WIDTH;
                cnt_q   <= '0;
                state_q <= IDLE;
              end
            end else begin
              shift_q <= shift_q << BYTE_WIDTH;
              cnt_q   <= cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_valid = (state_q == SEND);
  assign bus.o_busy  = (state_q == SEND);
  assign bus.o_data  = shift_q[DATA_WIDTH-1 -: BYTE_WIDTH];

endmodule
